// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file / scoreboard slice.
//   DEF_DATA_W, DEF_NUM_REGS, DEF_NUM_RD : default parameter values
//   addr_w(n)                            : address width for an n-entry array
package rf_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;

  // Address width for an n-entry array; never returns zero so that a
  // degenerate array still has a legal one-bit index.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_sb_board.sv
// Scoreboard for a register file: one pending (busy) bit per register,
// claim acceptance and a running count of pending registers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   we, wr_addr  : register write; clears the pending bit of wr_addr
//   claim        : request to mark claim_addr pending
//   claim_addr   : register to claim
//   claim_ack    : combinational, claim accepted this cycle
//   busy         : registered pending bits, one per register
//   busy_cnt     : registered population count of busy
module rf_sb_board
  import rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_w(NUM_REGS),
  localparam int CNT_W   = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic                claim,
  input  logic [AW-1:0]       claim_addr,
  output logic                claim_ack,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    busy_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  logic zero_wr;
  logic zero_claim;
  logic clr_fire;
  logic set_fire;
  logic cnt_inc;
  logic cnt_dec;

  // The hard-wired zero register is never tracked: writes to it do not
  // clear anything and claims of it are acknowledged but not recorded.
  assign zero_wr    = ZERO_REG && (wr_addr == '0);
  assign zero_claim = ZERO_REG && (claim_addr == '0);

  // A claim of a busy register is still accepted when the result that
  // frees it is being written back in the same cycle.
  assign claim_ack = claim &&
                     (!busy_q[claim_addr] || (we && (wr_addr == claim_addr)));

  assign clr_fire = we && !zero_wr;
  assign set_fire = claim_ack && !zero_claim;

  always_comb begin
    // NOTE: combinational blocks take a full default first so no path
    // leaves a variable unassigned (which would infer a latch); blocking
    // assignments make the later set override the earlier clear, so a
    // same-edge write and claim to one register leaves it busy.
    busy_d = busy_q;
    if (clr_fire) busy_d[wr_addr]    = 1'b0;
    if (set_fire) busy_d[claim_addr] = 1'b1;
  end

  // Incremental count: a set only adds when the bit was idle, a clear only
  // subtracts when the bit was busy and is not re-set on the same edge.
  assign cnt_inc = set_fire && !busy_q[claim_addr];
  assign cnt_dec = clr_fire && busy_q[wr_addr] &&
                   !(set_fire && (claim_addr == wr_addr));

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its inputs from before the edge.
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/rf_sb.sv
// Register file with write-through bypass and a pending-result scoreboard.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rd_addr     : packed read addresses, port i at [i*AW +: AW]
//   rd_data     : packed combinational read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy     : pending bit of each addressed register (no same-cycle bypass)
//   we, wr_addr, wr_data : register write
//   claim, claim_addr    : mark a register as awaiting a long-latency result
//   claim_ack   : combinational, claim accepted this cycle
//   busy_cnt    : registered number of pending registers
module rf_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim,
  input  logic [AW-1:0]            claim_addr,
  output logic                     claim_ack,
  output logic [AW:0]              busy_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_fire;

  assign wr_fire = we && !(ZERO_REG && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array carries an asynchronous reset because it must read
    // as zero the moment reset asserts; this keeps it in flops rather than
    // letting it map onto a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[p*AW +: AW];

    // Bypass is gated by rst_n so the ports read zero throughout reset,
    // even if a write is presented while reset is held.
    always_comb begin
      data = regs_q[addr];
      if (rst_n && we && (wr_addr == addr)) data = wr_data;
      if (ZERO_REG && (addr == '0))         data = '0;
    end

    assign rd_data[p*DATA_W +: DATA_W] = data;
    assign rd_busy[p]                  = busy[addr];
  end

  rf_sb_board #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_board (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .wr_addr    (wr_addr),
    .claim      (claim),
    .claim_addr (claim_addr),
    .claim_ack  (claim_ack),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

endmodule

// File: tb/tb_rf_sb.sv
// Directed bench for rf_sb with default parameters (32 x 32-bit, 2 read
// ports, hard-wired zero register).
module tb_rf_sb;

  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic [1:0]    rd_busy;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          claim;
  logic [AW-1:0] claim_addr;
  logic          claim_ack;
  logic [AW:0]   busy_cnt;

  int errors = 0;
  int checks = 0;

  rf_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim      (claim),
    .claim_addr (claim_addr),
    .claim_ack  (claim_ack),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    we    = 1'b0;
    claim = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    claim = 1'b0; claim_addr = '0;
    set_rd(5'd5, 5'd0);
    repeat (2) cycle();

    // Reset state
    check("rst_cnt",   32'(busy_cnt), 32'd0);
    check("rst_rd0",   rd_data[31:0], 32'd0);
    check("rst_busy",  32'(rd_busy),  32'd0);
    rst_n = 1'b1;
    cycle();

    // Write r5, read it back next cycle
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    #1 check("r5_read", rd_data[31:0], 32'hDEADBEEF);

    // Write to r0 is dropped and never bypassed
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; set_rd(5'd5, 5'd0);
    #1 check("r0_bypass", rd_data[63:32], 32'd0);
    cycle();
    idle();
    #1 check("r0_read", rd_data[63:32], 32'd0);

    // Same-cycle bypass on port 1; port 0 keeps its stored value
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; set_rd(5'd5, 5'd7);
    #1 check("byp_p1", rd_data[63:32], 32'hA5A5A5A5);
    check("byp_p0", rd_data[31:0], 32'hDEADBEEF);
    cycle();
    idle();
    #1 check("r7_read", rd_data[63:32], 32'hA5A5A5A5);

    // Claim r3, reclaim rejected, write clears
    claim = 1'b1; claim_addr = 5'd3; set_rd(5'd3, 5'd7);
    #1 check("clm3_ack", 32'(claim_ack), 32'd1);
    check("clm3_busy_pre", 32'(rd_busy[0]), 32'd0);
    cycle();
    check("clm3_cnt",  32'(busy_cnt),   32'd1);
    check("clm3_busy", 32'(rd_busy[0]), 32'd1);
    #1 check("reclm3_ack", 32'(claim_ack), 32'd0);
    cycle();
    check("reclm3_cnt", 32'(busy_cnt), 32'd1);
    claim = 1'b0; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    cycle();
    idle();
    check("wr3_cnt",  32'(busy_cnt),   32'd0);
    check("wr3_busy", 32'(rd_busy[0]), 32'd0);

    // r9: write and claim on the same edge while busy
    claim = 1'b1; claim_addr = 5'd9; set_rd(5'd9, 5'd7);
    cycle();
    check("clm9_cnt", 32'(busy_cnt), 32'd1);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    #1 check("wc9_ack", 32'(claim_ack), 32'd1);
    check("wc9_byp", rd_data[31:0], 32'h99);
    cycle();
    idle();
    #1 check("wc9_data", rd_data[31:0], 32'h99);
    check("wc9_busy", 32'(rd_busy[0]), 32'd1);
    check("wc9_cnt",  32'(busy_cnt),   32'd1);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
    cycle();
    idle();
    check("wr9_cnt", 32'(busy_cnt), 32'd0);

    // Write to an idle register leaves the count alone
    we = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
    cycle();
    idle();
    check("wr10_cnt", 32'(busy_cnt), 32'd0);

    // Claim every nonzero register, then r0
    for (int r = 1; r < 32; r++) begin
      claim = 1'b1; claim_addr = 5'(r);
      cycle();
    end
    claim = 1'b0;
    check("all_cnt", 32'(busy_cnt), 32'd31);
    claim = 1'b1; claim_addr = 5'd0; set_rd(5'd0, 5'd31);
    #1 check("clm0_ack", 32'(claim_ack), 32'd1);
    cycle();
    claim = 1'b0;
    check("clm0_cnt",  32'(busy_cnt),   32'd31);
    check("clm0_busy", 32'(rd_busy[0]), 32'd0);
    check("r31_busy",  32'(rd_busy[1]), 32'd1);
    claim = 1'b1; claim_addr = 5'd4;
    #1 check("reclm4_ack", 32'(claim_ack), 32'd0);
    claim = 1'b0;

    // Fresh reset, build up four pending registers
    rst_n = 1'b0;
    #2 check("rst2_cnt", 32'(busy_cnt), 32'd0);
    rst_n = 1'b1;
    cycle();
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFE;
    cycle();
    idle();
    for (int r = 1; r <= 4; r++) begin
      claim = 1'b1; claim_addr = 5'(r);
      cycle();
    end
    claim = 1'b0;
    check("pre_cnt", 32'(busy_cnt), 32'd4);

    // Mid-cycle reset with a write and a (rejected) claim on the inputs
    claim = 1'b1; claim_addr = 5'd3;
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'h77; set_rd(5'd12, 5'd3);
    #1 check("pre_ack", 32'(claim_ack), 32'd0);
    check("pre_byp", rd_data[31:0], 32'h77);
    check("pre_busy", 32'(rd_busy[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("mid_cnt",  32'(busy_cnt),     32'd0);
    check("mid_rd0",  rd_data[31:0],  32'd0);
    check("mid_rd1",  rd_data[63:32], 32'd0);
    check("mid_busy", 32'(rd_busy),   32'd0);
    check("mid_ack",  32'(claim_ack), 32'd1);
    idle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("post_cnt",  32'(busy_cnt),  32'd0);
    check("post_r12",  rd_data[31:0], 32'd0);
    check("post_busy", 32'(rd_busy),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
